gsim_mtx_fetch: RTL and testbench

//  Parametrised matrix-memory fetch engine for the Gauss-Seidel machine. Streams M matrices of
//  (N+1) words each (word 0 = b vector, words 1..N = rows of A) from matrix memory.
//  Has a credit-limited request pipeline, multiple in-flight reads and an output FIFO with

---
 rtl/gsim_mtx_fetch.sv | 210 +++++++++++++++++++++
 tb/tb_gsim_mtx_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_mtx_fetch.sv
// gsim_mtx_fetch: matrix-memory fetch engine for the Gauss-Seidel machine.
// Streams M matrices of (N+1) words each (word 0 = b, words 1..N = rows of A).
// Reads are credit limited so that in-flight reads plus buffered words never
// exceed FIFO_DEPTH. Returned words are buffered, tagged and handed downstream.
//
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_start            start pulse, honoured only in IDLE
//   i_matrix_num       matrix count M, latched on accepted start
//   o_busy / o_done    run in progress / one-cycle completion pulse
//   o_mem_rreq/_addr   read request and address, held until i_mem_rrdy
//   i_mem_dout(_vld)   read data, in request order
//   o_row_vld/_data    output FIFO head
//   o_row_mtx/_idx     tag of the head word (matrix, word index)
//   o_row_last         head is the final word of the final matrix
//   i_row_rdy          downstream pop
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_start
// FETCH | issuing read requests as credits allow
// DRAIN | all requests issued; waiting for returns and FIFO to empty
// DONE  | one-cycle completion pulse
module gsim_mtx_fetch #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 10,
  parameter int N          = 16,
  parameter int MNUM_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0,
  localparam int IDX_W     = $clog2(N + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [MNUM_W-1:0] i_matrix_num,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_rreq,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic [DATA_W-1:0] i_mem_dout,
  input  logic              i_mem_dout_vld,
  output logic              o_row_vld,
  output logic [DATA_W-1:0] o_row_data,
  output logic [MNUM_W-1:0] o_row_mtx,
  output logic [IDX_W-1:0]  o_row_idx,
  output logic              o_row_last,
  input  logic              i_row_rdy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N);
  localparam logic [CNT_W:0]    CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [MNUM_W-1:0] m_total_q, m_total_d;
  logic [MNUM_W-1:0] m_req_q, m_req_d;
  logic [IDX_W-1:0]  r_req_q, r_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [MNUM_W-1:0] m_ret_q, m_ret_d;
  logic [IDX_W-1:0]  r_ret_q, r_ret_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [MNUM_W-1:0] fifo_mtx_q  [FIFO_DEPTH];
  logic [IDX_W-1:0]  fifo_idx_q  [FIFO_DEPTH];

  logic mem_rreq, accept, push, pop, req_last, start_ok;

  always_comb begin
    // Credit check covers reads still in flight, so the FIFO can never overflow.
    mem_rreq = (state_q == S_FETCH) &&
               (({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < CREDITS);
    accept   = mem_rreq & i_mem_rrdy;
    // Returns with nothing outstanding (e.g. stale data after reset) are dropped.
    push     = i_mem_dout_vld & (inflight_q != '0);
    pop      = (fifo_cnt_q != '0) & i_row_rdy;
    req_last = (m_req_q == m_total_q - MNUM_W'(1)) && (r_req_q == LAST_IDX);
    start_ok = (state_q == S_IDLE) & i_start;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !push)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && push) inflight_d = inflight_q - CNT_W'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  end

  // Return-side tag counter, independent of the request counter.
  always_comb begin
    m_ret_d = m_ret_q;
    r_ret_d = r_ret_q;
    if (start_ok) begin
      m_ret_d = '0;
      r_ret_d = '0;
    end else if (push) begin
      if (r_ret_q == LAST_IDX) begin
        r_ret_d = '0;
        m_ret_d = m_ret_q + MNUM_W'(1);
      end else begin
        r_ret_d = r_ret_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    m_total_d = m_total_q;
    m_req_d   = m_req_q;
    r_req_d   = r_req_q;
    addr_d    = addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          m_total_d = i_matrix_num;
          m_req_d   = '0;
          r_req_d   = '0;
          addr_d    = BASE;
          state_d   = (i_matrix_num == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (accept) begin
          addr_d = addr_q + ADDR_W'(1);
          if (req_last) begin
            state_d = S_DRAIN;
          end else if (r_req_q == LAST_IDX) begin
            r_req_d = '0;
            m_req_d = m_req_q + MNUM_W'(1);
          end else begin
            r_req_d = r_req_q + IDX_W'(1);
          end
        end
      end
      // Looking at next-cycle counts makes o_done follow the final pop by one cycle.
      S_DRAIN: if ((inflight_d == '0) && (fifo_cnt_d == '0)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      m_total_q  <= '0;
      m_req_q    <= '0;
      r_req_q    <= '0;
      addr_q     <= '0;
      m_ret_q    <= '0;
      r_ret_q    <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_total_q  <= m_total_d;
      m_req_q    <= m_req_d;
      r_req_q    <= r_req_d;
      addr_q     <= addr_d;
      m_ret_q    <= m_ret_d;
      r_ret_q    <= r_ret_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is reset so the head outputs are never X.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_mtx_q[i]  <= '0;
        fifo_idx_q[i]  <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= i_mem_dout;
      fifo_mtx_q[wr_ptr_q]  <= m_ret_q;
      fifo_idx_q[wr_ptr_q]  <= r_ret_q;
    end
  end

  assign o_busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign o_done     = (state_q == S_DONE);
  assign o_mem_rreq = mem_rreq;
  assign o_mem_addr = addr_q;
  assign o_row_vld  = (fifo_cnt_q != '0);
  assign o_row_data = fifo_data_q[rd_ptr_q];
  assign o_row_mtx  = fifo_mtx_q[rd_ptr_q];
  assign o_row_idx  = fifo_idx_q[rd_ptr_q];
  assign o_row_last = o_row_vld && (o_row_mtx == m_total_q - MNUM_W'(1)) &&
                      (o_row_idx == LAST_IDX);

endmodule

// File: tb/tb_gsim_mtx_fetch.sv
module tb_gsim_mtx_fetch;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 10;
  localparam int N      = 16;
  localparam int MNUM_W = 5;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;
  localparam int IDX_W  = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [MNUM_W-1:0] i_matrix_num;
  logic              o_busy, o_done, o_mem_rreq;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_rrdy;
  logic [DATA_W-1:0] i_mem_dout;
  logic              i_mem_dout_vld;
  logic              o_row_vld;
  logic [DATA_W-1:0] o_row_data;
  logic [MNUM_W-1:0] o_row_mtx;
  logic [IDX_W-1:0]  o_row_idx;
  logic              o_row_last;
  logic              i_row_rdy;

  always #5 clk = ~clk;

  gsim_mtx_fetch #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N(N), .MNUM_W(MNUM_W),
    .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_matrix_num(i_matrix_num),
    .o_busy(o_busy), .o_done(o_done), .o_mem_rreq(o_mem_rreq), .o_mem_addr(o_mem_addr),
    .i_mem_rrdy(i_mem_rrdy), .i_mem_dout(i_mem_dout), .i_mem_dout_vld(i_mem_dout_vld),
    .o_row_vld(o_row_vld), .o_row_data(o_row_data), .o_row_mtx(o_row_mtx),
    .o_row_idx(o_row_idx), .o_row_last(o_row_last), .i_row_rdy(i_row_rdy)
  );

  logic [DATA_W-1:0] mem [1024];

  int n_vec = 0;
  int n_miss = 0;

  // reference model state
  int cyc = 0;
  int busy_m = 0, done_m = 0, fetching_m = 0;
  int total = 0, acc_cnt = 0, pop_cnt = 0, fifo_occ = 0, stale_n = 0;
  int last_due = 0, lat_lo = 1, lat_hi = 1;
  int rrdy_mode = 0, rowrdy_mode = 0;
  int start_req = 0, start_mnum = 0;
  int pq_due[$];
  int pq_addr[$];

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int word_addr(input int k);
    int m, r;
    m = k / (N + 1);
    r = k % (N + 1);
    return (BASE + m * (N + 1) + r) % 1024;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rreq"}, o_mem_rreq, 0);
    chk({tag, "_addr"}, o_mem_addr, 0);
    chk({tag, "_row_vld"}, o_row_vld, 0);
    chk({tag, "_row_data"}, o_row_data, 0);
    chk({tag, "_row_mtx"}, o_row_mtx, 0);
    chk({tag, "_row_idx"}, o_row_idx, 0);
    chk({tag, "_row_last"}, o_row_last, 0);
  endtask

  // One clock: drive inputs at the falling edge, check the state left by the
  // previous rising edge, then account for what the next rising edge will do.
  task automatic tick();
    int ret_now, pop_now, done_next, due, k, infl;
    @(negedge clk);
    cyc++;
    i_start      = (start_req != 0);
    i_matrix_num = MNUM_W'(start_mnum);
    case (rrdy_mode)
      0:       i_mem_rrdy = 1'b1;
      1:       i_mem_rrdy = (cyc % 2) == 0;
      default: i_mem_rrdy = ($urandom_range(0, 1) == 1);
    endcase
    case (rowrdy_mode)
      0:       i_row_rdy = 1'b1;
      1:       i_row_rdy = 1'b0;
      default: i_row_rdy = ($urandom_range(0, 3) != 0);
    endcase

    infl = pq_due.size() - stale_n;
    ret_now = 0;
    if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
      i_mem_dout_vld = 1'b1;
      i_mem_dout     = mem[pq_addr[0]];
      void'(pq_due.pop_front());
      void'(pq_addr.pop_front());
      if (stale_n > 0) stale_n--;
      else ret_now = 1;
    end else begin
      i_mem_dout_vld = 1'b0;
      i_mem_dout     = {8{$urandom}};
    end

    chk("rreq", o_mem_rreq, (fetching_m != 0) && (acc_cnt < total) && (infl + fifo_occ < DEPTH));
    chk("inflight_le_depth", infl <= DEPTH, 1);
    if (o_mem_rreq && acc_cnt < total) chk("addr_pending", o_mem_addr, word_addr(acc_cnt));
    chk("busy", o_busy, busy_m != 0);
    chk("done", o_done, done_m != 0);
    chk("row_vld", o_row_vld, fifo_occ != 0);

    done_next = 0;
    if (i_start && busy_m == 0 && done_m == 0) begin
      total   = int'(i_matrix_num) * (N + 1);
      acc_cnt = 0;
      pop_cnt = 0;
      if (total == 0) done_next = 1;
      else begin
        busy_m     = 1;
        fetching_m = 1;
      end
    end

    if (o_mem_rreq && i_mem_rrdy) begin
      chk("req_addr", o_mem_addr, word_addr(acc_cnt));
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pq_due.push_back(due);
      pq_addr.push_back(int'(o_mem_addr));
      acc_cnt++;
      if (acc_cnt == total) fetching_m = 0;
    end

    pop_now = 0;
    if (o_row_vld && i_row_rdy) begin
      pop_now = 1;
      chk("no_extra_pop", pop_cnt < total, 1);
      if (pop_cnt < total) begin
        k = pop_cnt;
        chk("row_data", o_row_data, mem[word_addr(k)]);
        chk("row_mtx", o_row_mtx, k / (N + 1));
        chk("row_idx", o_row_idx, k % (N + 1));
        chk("row_last", o_row_last, k == total - 1);
        pop_cnt++;
        if (pop_cnt == total) begin
          busy_m    = 0;
          done_next = 1;
        end
      end
    end
    fifo_occ = fifo_occ + ret_now - pop_now;
    done_m   = done_next;
  endtask

  task automatic start_run(input int m);
    start_req  = 1;
    start_mnum = m;
    tick();
    start_req  = 0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((busy_m != 0 || done_m != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("run_timeout", n < limit, 1);
    chk("words_delivered", pop_cnt, total);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    busy_m     = 0;
    done_m     = 0;
    fetching_m = 0;
    fifo_occ   = 0;
    total      = 0;
    acc_cnt    = 0;
    pop_cnt    = 0;
    stale_n    = pq_due.size();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int found, n;
    for (int i = 0; i < 1024; i++) mem[i] = {8{$urandom}};
    rst_n          = 1'b0;
    i_start        = 1'b0;
    i_matrix_num   = '0;
    i_mem_rrdy     = 1'b0;
    i_mem_dout     = '0;
    i_mem_dout_vld = 1'b0;
    i_row_rdy      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // 1) single matrix, fixed latency 2, no backpressure
    lat_lo = 2; lat_hi = 2; rrdy_mode = 0; rowrdy_mode = 0;
    start_run(1);
    wait_done(300);
    chk("t1_requests", acc_cnt, N + 1);

    // 2) downstream stalled: only credits worth of requests go out
    start_run(3);
    rowrdy_mode = 1;
    repeat (30) tick();
    chk("t2_credit_stall", acc_cnt, DEPTH);
    rowrdy_mode = 0;
    wait_done(600);

    // 3) toggling request ready, random latency, random downstream ready
    lat_lo = 1; lat_hi = 5; rrdy_mode = 1; rowrdy_mode = 2;
    start_run(2);
    wait_done(1500);
    rrdy_mode = 2;
    start_run(3);
    wait_done(2500);

    // 4) zero matrices
    rrdy_mode = 0; rowrdy_mode = 0;
    start_run(0);
    wait_done(10);
    chk("t4_no_requests", acc_cnt, 0);

    // 5) restart attempt mid-fetch is ignored
    lat_lo = 1; lat_hi = 3;
    start_run(2);
    repeat (10) tick();
    start_req = 1; start_mnum = 7;
    tick();
    start_req = 0;
    wait_done(800);
    chk("t5_orig_M", pop_cnt, 2 * (N + 1));

    // 6) reset while draining with two reads outstanding
    lat_lo = 5; lat_hi = 5;
    start_run(1);
    found = 0;
    n = 0;
    while (found == 0 && n < 300) begin
      if (acc_cnt == total && (pq_due.size() - stale_n) == 2) found = 1;
      else begin
        tick();
        n++;
      end
    end
    chk("t6_reach_drain", found, 1);
    do_reset();
    repeat (8) tick();
    chk("t6_stale_flushed", pq_due.size(), 0);
    lat_lo = 1; lat_hi = 3;
    start_run(1);
    wait_done(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
